// File: rtl/spi_pkg.sv
// Shared SPI frame definitions used by both the transmitter and the receiver side.
package spi_pkg;

    localparam int unsigned SPI_FRAME_BITS = 8;
    localparam int unsigned SPI_BIT_W      = $clog2(SPI_FRAME_BITS);

    typedef logic [SPI_FRAME_BITS-1:0] spi_byte_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_HIGH,
        ST_LOW,
        ST_HOLD,
        ST_GAP
    } spi_tx_state_t;

    // True for every state in which cs is asserted and sdo carries frame data.
    function automatic logic frame_active(input spi_tx_state_t s);
        return (s == ST_SETUP) || (s == ST_HIGH) || (s == ST_LOW) || (s == ST_HOLD);
    endfunction

endpackage

// File: rtl/spi_tx_fifo.sv
// Small synchronous byte FIFO with registered level and status flags.
module spi_tx_fifo
    import spi_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     wr_en,
    input  spi_byte_t                wr_data,
    input  logic                     rd_en,
    output spi_byte_t                rd_data_c,
    output logic                     full,
    output logic                     empty,
    output logic                     wr_ready,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    spi_byte_t       mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [LW-1:0]   level_n;
    logic            push;
    logic            pop;

    assign push      = wr_en && !full;
    assign pop       = rd_en && !empty;
    assign rd_data_c = mem[rd_ptr];

    // Occupancy after this cycle's push/pop; simultaneous push and pop cancel.
    always_comb begin
        level_n = level;
        if (push && !pop) begin
            level_n = level + LW'(1);
        end else if (pop && !push) begin
            level_n = level - LW'(1);
        end
    end

    // Storage array; contents need no reset since level gates every read.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers (wrapping modulo DEPTH), level and registered status flags.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            full     <= 1'b0;
            empty    <= 1'b1;
            wr_ready <= 1'b1;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            level    <= level_n;
            full     <= (level_n == LW'(DEPTH));
            empty    <= (level_n == '0);
            wr_ready <= (level_n != LW'(DEPTH));
        end
    end

endmodule

// File: rtl/spi_tx.sv
// SPI mode-0 controller-side transmitter: one framed MSB-first byte per FIFO entry.
module spi_tx
    import spi_pkg::*;
#(
    parameter int unsigned CLK_DIV = 2,
    parameter int unsigned DEPTH   = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [7:0]               in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic                     sck,
    output logic                     cs,
    output logic                     sdo,
    output logic                     busy,
    output logic                     frame_done,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int unsigned        PHASE_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [PHASE_W-1:0] PHASE_LAST = PHASE_W'(CLK_DIV - 1);

    spi_tx_state_t          state;
    spi_tx_state_t          state_n;
    logic [PHASE_W-1:0]     phase;
    logic [PHASE_W-1:0]     phase_n;
    spi_byte_t              shift;
    spi_byte_t              shift_n;
    logic [SPI_BIT_W-1:0]   bit_cnt;
    logic [SPI_BIT_W-1:0]   bit_cnt_n;
    logic                   phase_last;
    logic                   pop_c;

    spi_byte_t              head_c;
    logic                   fifo_full;
    logic                   fifo_empty;

    logic                   cs_c;
    logic                   sck_c;
    logic                   sdo_c;
    logic                   busy_c;
    logic                   frame_done_c;

    spi_tx_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .wr_en     (in_valid && !fifo_full),
        .wr_data   (in_data),
        .rd_en     (pop_c),
        .rd_data_c (head_c),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .wr_ready  (in_ready),
        .level     (level)
    );

    assign phase_last = (phase == PHASE_LAST);

    // FSM state, phase divider, shifter and bit counter registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= ST_IDLE;
            phase   <= '0;
            shift   <= '0;
            bit_cnt <= '0;
        end else begin
            state   <= state_n;
            phase   <= phase_n;
            shift   <= shift_n;
            bit_cnt <= bit_cnt_n;
        end
    end

    // Next-state logic: every non-idle state lasts exactly CLK_DIV cycles.
    always_comb begin
        state_n   = state;
        shift_n   = shift;
        bit_cnt_n = bit_cnt;
        pop_c     = 1'b0;
        phase_n   = (state == ST_IDLE || phase_last) ? '0 : phase + PHASE_W'(1);
        unique case (state)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop_c     = 1'b1;
                    shift_n   = head_c;
                    bit_cnt_n = SPI_BIT_W'(SPI_FRAME_BITS - 1);
                    state_n   = ST_SETUP;
                end
            end
            ST_SETUP: begin
                if (phase_last) state_n = ST_HIGH;
            end
            ST_HIGH: begin
                if (phase_last) begin
                    if (bit_cnt == '0) begin
                        state_n = ST_HOLD;
                    end else begin
                        shift_n   = {shift[SPI_FRAME_BITS-2:0], 1'b0};
                        bit_cnt_n = bit_cnt - SPI_BIT_W'(1);
                        state_n   = ST_LOW;
                    end
                end
            end
            ST_LOW: begin
                if (phase_last) state_n = ST_HIGH;
            end
            ST_HOLD: begin
                if (phase_last) state_n = ST_GAP;
            end
            ST_GAP: begin
                if (phase_last) state_n = ST_IDLE;
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    // Output decode from the upcoming state so the pins change in step with it.
    always_comb begin
        cs_c         = frame_active(state_n);
        sck_c        = (state_n == ST_HIGH);
        sdo_c        = frame_active(state_n) ? shift_n[SPI_FRAME_BITS-1] : 1'b0;
        busy_c       = (state_n != ST_IDLE);
        frame_done_c = (state_n == ST_GAP) && (state != ST_GAP);
    end

    // Registered, glitch-free pin drivers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cs         <= 1'b0;
            sck        <= 1'b0;
            sdo        <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            cs         <= cs_c;
            sck        <= sck_c;
            sdo        <= sdo_c;
            busy       <= busy_c;
            frame_done <= frame_done_c;
        end
    end

endmodule

// File: tb/tb_spi_tx.sv
// Directed bench for spi_tx: a CLK_DIV=2 instance and a CLK_DIV=1 instance,
// each decoded by a small mode-0 receiver model.
module tb_spi_tx;

    logic       clk = 1'b0;
    logic       rst0_n, rst1_n;
    logic [7:0] din0, din1;
    logic       vld0, vld1;
    logic       rdy0, sck0, cs0, sdo0, busy0, fd0;
    logic       rdy1, sck1, cs1, sdo1, busy1, fd1;
    logic [2:0] lvl0, lvl1;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    spi_tx #(.CLK_DIV(2), .DEPTH(4)) dut0 (
        .clk(clk), .reset_n(rst0_n), .in_data(din0), .in_valid(vld0), .in_ready(rdy0),
        .sck(sck0), .cs(cs0), .sdo(sdo0), .busy(busy0), .frame_done(fd0), .level(lvl0)
    );

    spi_tx #(.CLK_DIV(1), .DEPTH(4)) dut1 (
        .clk(clk), .reset_n(rst1_n), .in_data(din1), .in_valid(vld1), .in_ready(rdy1),
        .sck(sck1), .cs(cs1), .sdo(sdo1), .busy(busy1), .frame_done(fd1), .level(lvl1)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Receiver model: sample sdo on sck rise while cs high, latch byte when cs falls.
    logic       cs_w [2];
    logic       sck_w [2];
    logic       sdo_w [2];
    logic       fd_w [2];
    logic       rst_w [2];
    logic       cs_p [2];
    logic       sck_p [2];
    logic [7:0] sh [2];
    int         cs_len [2];
    int         rises [2];
    int         gap_cnt [2];
    logic       had_frame [2];
    logic [7:0] rx_byte [2][64];
    int         rx_len [2][64];
    int         rx_rises [2][64];
    int         rx_n [2];
    int         fd_cnt [2];
    int         rd_idx [2];
    int         min_gap = 1000;
    int         max_lvl = 0;

    assign cs_w[0]  = cs0;   assign cs_w[1]  = cs1;
    assign sck_w[0] = sck0;  assign sck_w[1] = sck1;
    assign sdo_w[0] = sdo0;  assign sdo_w[1] = sdo1;
    assign fd_w[0]  = fd0;   assign fd_w[1]  = fd1;
    assign rst_w[0] = rst0_n; assign rst_w[1] = rst1_n;

    initial begin
        for (int m = 0; m < 2; m++) begin
            cs_p[m] = 0; sck_p[m] = 0; sh[m] = 0; cs_len[m] = 0; rises[m] = 0;
            gap_cnt[m] = 0; had_frame[m] = 0; rx_n[m] = 0; fd_cnt[m] = 0;
        end
    end

    always @(negedge clk) begin
        for (int m = 0; m < 2; m++) begin
            if (!rst_w[m]) begin
                cs_len[m] = 0; rises[m] = 0; sh[m] = 0; had_frame[m] = 0; gap_cnt[m] = 0;
            end else begin
                if (cs_w[m]) begin
                    cs_len[m]++;
                    if (sck_w[m] && !sck_p[m]) begin
                        sh[m] = {sh[m][6:0], sdo_w[m]};
                        rises[m]++;
                    end
                    if (!cs_p[m] && had_frame[m] && m == 0 && gap_cnt[m] < min_gap)
                        min_gap = gap_cnt[m];
                end
                if (!cs_w[m] && cs_p[m]) begin
                    rx_byte[m][rx_n[m]]  = sh[m];
                    rx_len[m][rx_n[m]]   = cs_len[m];
                    rx_rises[m][rx_n[m]] = rises[m];
                    rx_n[m]++;
                    cs_len[m] = 0; rises[m] = 0; sh[m] = 0;
                    had_frame[m] = 1; gap_cnt[m] = 1;
                end else if (!cs_w[m]) begin
                    gap_cnt[m]++;
                end
                if (fd_w[m]) fd_cnt[m]++;
            end
            cs_p[m]  = cs_w[m];
            sck_p[m] = sck_w[m];
        end
        if (rst0_n) begin
            if (int'(lvl0) > max_lvl) max_lvl = int'(lvl0);
            chk("ready_vs_level", 32'(rdy0), 32'(lvl0 != 3'd4));
        end
    end

    // Present one byte, hold it until accepted; returns at the negedge after acceptance.
    task automatic push(input int m, input logic [7:0] b, output int stalls);
        stalls = 0;
        if (m == 0) begin din0 = b; vld0 = 1'b1; end
        else        begin din1 = b; vld1 = 1'b1; end
        while (((m == 0) ? rdy0 : rdy1) == 1'b0 && stalls < 200) begin
            stalls++;
            @(negedge clk);
        end
        if (stalls >= 200) chk("push_ready", 32'((m == 0) ? rdy0 : rdy1), 32'd1);
        @(posedge clk);
        @(negedge clk);
        if (m == 0) vld0 = 1'b0; else vld1 = 1'b0;
    endtask

    task automatic wait_frame(input int m, input logic [7:0] exp, input int exp_len, input string tag);
        int n = 0;
        while (rx_n[m] <= rd_idx[m] && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (rx_n[m] <= rd_idx[m]) begin
            chk({tag, "_timeout"}, 32'(rx_n[m]), 32'(rd_idx[m] + 1));
            return;
        end
        chk({tag, "_byte"},  32'(rx_byte[m][rd_idx[m]]), 32'(exp));
        chk({tag, "_cslen"}, 32'(rx_len[m][rd_idx[m]]), 32'(exp_len));
        chk({tag, "_rises"}, 32'(rx_rises[m][rd_idx[m]]), 32'd8);
        rd_idx[m]++;
    endtask

    logic [7:0] b2b  [4] = '{8'h01, 8'h80, 8'hFF, 8'h00};
    logic [7:0] six  [6] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    logic [7:0] loop [3] = '{8'h00, 8'hFF, 8'h96};

    initial begin
        int st;
        int tot;
        int n;
        int rx_before;
        rd_idx[0] = 0; rd_idx[1] = 0;
        rst0_n = 1'b0; rst1_n = 1'b0;
        din0 = '0; din1 = '0; vld0 = 1'b0; vld1 = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_cs",    32'(cs0),    32'd0);
        chk("rst_sck",   32'(sck0),   32'd0);
        chk("rst_sdo",   32'(sdo0),   32'd0);
        chk("rst_busy",  32'(busy0),  32'd0);
        chk("rst_fd",    32'(fd0),    32'd0);
        chk("rst_level", 32'(lvl0),   32'd0);
        chk("rst_ready", 32'(rdy0),   32'd1);
        chk("rst_cs1",   32'(cs1),    32'd0);
        rst0_n = 1'b1; rst1_n = 1'b1;
        @(negedge clk);

        // Single byte 0xA5 with push-to-cs latency
        push(0, 8'hA5, st);
        chk("lat_cs_lo",  32'(cs0),  32'd0);
        chk("lat_level1", 32'(lvl0), 32'd1);
        @(negedge clk);
        chk("lat_cs_hi",  32'(cs0),  32'd1);
        chk("lat_busy",   32'(busy0), 32'd1);
        chk("lat_level0", 32'(lvl0), 32'd0);
        wait_frame(0, 8'hA5, 34, "a5");
        repeat (3) @(negedge clk);
        chk("a5_idle_busy", 32'(busy0), 32'd0);
        chk("a5_fd_low",    32'(fd0),   32'd0);
        chk("a5_fd_count",  32'(fd_cnt[0]), 32'd1);

        // Back-to-back bytes
        for (int i = 0; i < 4; i++) begin
            chk("b2b_ready", 32'(rdy0), 32'd1);
            push(0, b2b[i], st);
        end
        for (int i = 0; i < 4; i++) wait_frame(0, b2b[i], 34, "b2b");
        chk("b2b_level_le4", 32'(max_lvl <= 4), 32'd1);
        chk("b2b_gap_ge3",   32'(min_gap >= 3), 32'd1);
        chk("b2b_fd_count",  32'(fd_cnt[0]), 32'(rx_n[0]));

        // Six bytes into a four-entry FIFO
        tot = 0;
        for (int i = 0; i < 6; i++) begin
            push(0, six[i], st);
            tot += st;
        end
        chk("full_stalled", 32'(tot > 0), 32'd1);
        chk("full_max_lvl", 32'(max_lvl), 32'd4);
        for (int i = 0; i < 6; i++) wait_frame(0, six[i], 34, "six");

        // Reset in the middle of 0x3C with 0x11 still buffered
        push(0, 8'h3C, st);
        push(0, 8'h11, st);
        n = 0;
        while (rises[0] < 4 && n < 200) begin @(negedge clk); n++; end
        chk("mid_cs",    32'(cs0),  32'd1);
        chk("mid_sdo",   32'(sdo0), 32'd1);
        chk("mid_level", 32'(lvl0), 32'd1);
        rx_before = rx_n[0];
        #2 rst0_n = 1'b0;
        #1;
        chk("async_cs",    32'(cs0),   32'd0);
        chk("async_sck",   32'(sck0),  32'd0);
        chk("async_sdo",   32'(sdo0),  32'd0);
        chk("async_level", 32'(lvl0),  32'd0);
        chk("async_busy",  32'(busy0), 32'd0);
        chk("async_ready", 32'(rdy0),  32'd1);
        repeat (3) @(negedge clk);
        chk("abort_noframe", 32'(rx_n[0]),   32'(rx_before));
        chk("abort_nofd",    32'(fd_cnt[0]), 32'(rx_n[0]));
        rst0_n = 1'b1;
        @(negedge clk);
        push(0, 8'h5A, st);
        wait_frame(0, 8'h5A, 34, "after_rst");
        repeat (80) @(negedge clk);
        chk("discarded", 32'(rx_n[0]), 32'(rd_idx[0]));

        // CLK_DIV = 1
        push(1, 8'hC3, st);
        wait_frame(1, 8'hC3, 17, "div1");
        repeat (3) @(negedge clk);
        chk("div1_fd", 32'(fd_cnt[1]), 32'd1);
        chk("div1_busy", 32'(busy1), 32'd0);

        // Loopback into the receiver model
        for (int i = 0; i < 3; i++) push(0, loop[i], st);
        for (int i = 0; i < 3; i++) wait_frame(0, loop[i], 34, "loop");
        repeat (4) @(negedge clk);
        chk("loop_fd_count", 32'(fd_cnt[0]), 32'(rx_n[0]));
        chk("final_busy",    32'(busy0), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_tx.md
# spi_tx

SPI controller-side transmitter: accepts bytes from FPGA logic over a valid/ready handshake, buffers them in a small FIFO, and serialises each byte MSB-first as one framed SPI transfer. Generates `sck`, `cs` and `sdo` from the system clock. It is the counterpart to the FPGA's SPI receiver: that receiver samples `sdi` on `sck` rising edge while `cs` is high and treats `~cs` as frame-done. The same frame format is used by the MCU and FPGA in both directions.

## Interface
Parameters:
- `CLK_DIV`, 2: system-clock cycles per `sck` half-period; legal range ≥1.
- `DEPTH`, 4: FIFO entries; power of two, ≥2.

Ports:
- `clk` input 1: system clock; all logic on rising edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `in_data` input 8: byte to transmit.
- `in_valid` input 1: `in_data` valid.
- `in_ready` output 1: FIFO can accept; equals `~full`.
- `sck` output 1: SPI clock, idle low (mode 0).
- `cs` output 1: frame enable, active-high.
- `sdo` output 1: serial data, MSB first.
- `busy` output 1: high whenever FSM not in IDLE.
- `frame_done` output 1: one-cycle pulse when `cs` falls after a frame.
- `level` output $clog2(DEPTH)+1: FIFO occupancy.

## Operation
- Push: `in_valid && in_ready` at a clock edge writes `in_data` at the tail; `level` increments.
- FSM states: IDLE, SETUP, HIGH, LOW, HOLD, GAP. A single phase counter counts 0..CLK_DIV-1 in every non-IDLE state; each state lasts exactly CLK_DIV cycles.
- IDLE: `cs`=0, `sck`=0, `sdo`=0. If FIFO non-empty, pop head into shift register, bit counter=7, go to SETUP.
- SETUP: `cs`=1, `sck`=0, `sdo`=shift[7]. Then go to HIGH.
- HIGH: `sck`=1; data stable (receiver samples here). At exit: if bit counter=0 go to HOLD; else shift left, decrement bit counter, go to LOW.
- LOW: `sck`=0, `sdo` presents next bit. Then go to HIGH.
- HOLD: `sck`=0, `cs`=1, `sdo` holds bit 0. Then go to GAP.
- GAP: `cs`=0, `sck`=0, `sdo`=0. `frame_done` pulses on the first GAP cycle. Then go to IDLE.
- Pop and push in the same cycle are both honoured. `level` is unchanged. Ordering is FIFO. Push when full is impossible because `in_ready`=0.
- Back-to-back bytes: each byte is its own frame. `cs` is low for at least CLK_DIV+1 cycles between frames (GAP plus one IDLE cycle).
- FIFO pointers wrap modulo DEPTH. Full when `level`==DEPTH, empty when 0.

## Timing
- Reset values, asserted asynchronously: `cs`=0, `sck`=0, `sdo`=0, `busy`=0, `frame_done`=0, `level`=0, `in_ready`=1, FSM=IDLE, FIFO emptied.
- Reset mid-frame aborts the frame immediately. `cs` drops with no `frame_done`, and buffered bytes are discarded.
- All outputs are registered; `sck`/`cs`/`sdo` are glitch-free.
- Push to `cs` rise: 2 cycles when idle and empty. Cycle 1 writes the FIFO; cycle 2 IDLE sees non-empty and pops; `cs`=1 from the following edge.
- `cs` high duration: 17·CLK_DIV cycles (SETUP + 8×HIGH + 7×LOW + HOLD). `sck` makes exactly 8 rising edges per frame.
- `sdo` changes only on `sck` falling transitions or at SETUP entry. Setup and hold around each `sck` rise are ≥CLK_DIV cycles.
- Frame period for back-to-back bytes: 18·CLK_DIV+1 cycles.

## Structure
- Shared package `spi_pkg`:
  - FSM state enum `spi_tx_state_t`.
  - `SPI_FRAME_BITS`=8.
  - Shared between transmitter and receiver side.
- Sub-module `spi_tx_fifo` (DEPTH×8 synchronous FIFO with level, full, empty, async active-low reset). The FSM, divider and shifter live in `spi_tx`.

## Test plan
- Reset then push 0xA5 with CLK_DIV=2 -> `cs` high 34 cycles. `sck` has 8 rises, where `sdo` samples 1,0,1,0,0,1,0,1. One `frame_done` pulse, then `busy`=0.
- Push 0x01, 0x80, 0xFF, 0x00 back-to-back -> `in_ready` stays 1, `level` peaks ≤4. Four separate frames in order, each decoding correctly. `cs` low ≥3 cycles between frames.
- Push 6 bytes in consecutive cycles while idle -> `in_ready` drops when `level`=4. No byte is lost once the handshake is respected; the output order matches the input order.
- Assert `reset_n`=0 during bit 3 of 0x3C -> `cs`/`sck`/`sdo` go to 0 asynchronously and `level`=0. No `frame_done` pulse. The next pushed byte 0x5A transmits cleanly.
- CLK_DIV=1, push 0xC3 -> `cs` high 17 cycles, 8 `sck` rises, decoded 0xC3.
- Loopback into the FPGA SPI receiver -> receiver `SIG`=pushed byte when `cs` falls, for 0x00, 0xFF, 0x96.
